ascii_rx_mux: RTL and testbench
===============================

# ascii_rx_mux

Merges the two character sources of the Apple-I keyboard port, the PS/2 keyboard decoder and the text-file paste stream, into one PIA-style receive register for the 6502. It sits directly downstream of the file-paste loader and the PS/2 decoder, and directly upstream of the CPU data bus mux at $D010/$D011. Keyboard characters are buffered in a small FIFO and have priority over the paste stream. Paste characters are paced and acknowledged through a valid/ack handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8, keyboard FIFO entries; power of two, minimum 2
- PACE, 4000, minimum clk25 cycles between two accepted paste characters; minimum 1
- UPCASE, 1, when 1, fold a–z to A–Z on both sources

Ports (one clock; reset is synchronous and active-high; clock port is `clk25`, reset port is `rst`):
- clk25  in  1  25 MHz system clock
- rst  in  1  synchronous, active-high reset
- ps2_ascii  in  8  keyboard character
- ps2_strobe  in  1  one-cycle pulse: ps2_ascii valid
- file_ascii  in  8  paste character
- file_valid  in  1  level: paste character pending; held until acknowledged
- file_ack  out  1  one-cycle pulse: file_ascii consumed
- file_abort  out  1  one-cycle pulse: ESC (8'h1B) typed on the keyboard
- cs  in  1  chip select, active high, one cycle per CPU access
- address  in  1  0 = RX data ($D010), 1 = RX status ($D011)
- dout  out  8  registered read data
- rx_ready  out  1  receive register full
- overflow  out  1  sticky: a keyboard character was dropped because the FIFO was full

## Operation
- Translation, shared by both sources and applied on entry:
  - drop bit 7
  - 7'h0A becomes 7'h0D
  - if UPCASE, 7'h61–7'h7A becomes 7'h41–7'h5A
  - translated 7'h00 is discarded: not enqueued, but a paste 7'h00 is still acked
- Keyboard path:
  - ps2_strobe pushes the translated character into the FIFO.
  - If the FIFO is full, the character is dropped and overflow is set.
  - An ESC keystroke is enqueued like any other character and also pulses file_abort on the following cycle.
- Receive register: rx_data[6:0] plus rx_full. The FSM has two states, EMPTY and FULL.
  - EMPTY → FULL when a load occurs. Load source priority:
    - the FIFO, if it is non-empty (pop)
    - otherwise the paste stream, if file_valid=1 and pace_cnt=0: file_ack pulses in the same cycle and pace_cnt loads PACE-1
  - FULL → EMPTY on a data read (cs=1, address=0).
- pace_cnt counts down to 0 every cycle and saturates at 0. Its width is $clog2(PACE)+1.
- CPU reads:
  - address=0: dout ← {1'b1, rx_data}
  - address=1: dout ← {rx_full, 7'b0}
  - dout holds its value when cs=0.
- rx_ready = rx_full.

## Timing
- Reset values:
  - dout = 8'h00
  - rx_full = 0, rx_data = 0
  - file_ack = 0, file_abort = 0, overflow = 0
  - FIFO empty, pace_cnt = 0, state EMPTY
- Reset mid-operation discards FIFO contents and any pending file_ack. file_valid may still be high after reset; it is accepted normally when allowed.
- dout updates on the clock edge that samples cs (1-cycle read latency).
- Clear-vs-load collision: a data read in FULL clears rx_full on that edge. No load occurs on the same edge; the earliest load is the next edge. There is therefore at least one cycle with rx_full=0 between two characters, so back-to-back status polls can observe the gap.
- FIFO latency: a strobe at edge N is visible in the FIFO at N+1. The earliest load is at edge N+1, giving rx_full=1 after N+1.
- Simultaneous push and pop on a full FIFO: the pop frees the slot and the push is accepted. Overflow is not set.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. An extra occupancy count, 0..FIFO_DEPTH, distinguishes full from empty.
- Paste throughput: at most one file_ack per PACE cycles, and never while rx_full=1.
- overflow clears only on rst.

## Structure
- Package ascii_rx_pkg holds:
  - constants ASC_CR = 7'h0D, ASC_LF = 7'h0A, ASC_ESC = 7'h1B
  - function ascii_xlate(in[7:0], upcase) returning 7 bits
- Sub-module ascii_char_fifo: synchronous FIFO with push/pop/full/empty/count and DEPTH and WIDTH parameters. It is instantiated once with WIDTH=7.

## Test plan
- Reset, then status read (cs=1, address=1) → dout=8'h00; rx_ready=0.
- Keyboard strobe 8'h61 with UPCASE=1 → rx_ready=1 within 2 cycles; data read → dout=8'hC1. The next status read → 8'h00.
- file_valid high with 8'h0A, 8'h68 queued and PACE=16 → file_ack pulses ≥16 cycles apart. Reads return 8'h8D, then 8'hC8.
- Keyboard strobe 8'h42 in the same cycle that a paste char is eligible → the keyboard char loads first (read 8'hC2). The paste char loads only after that read and is acked then.
- Nine keyboard strobes, FIFO_DEPTH=8, no reads → the first char is in the receive register, the FIFO holds 8, overflow=0. A tenth strobe sets overflow=1. Draining yields all 9 in order.
- Keyboard strobe 8'h1B during paste → one file_abort pulse; ESC is delivered as 8'h9B. Asserting rst mid-stream → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ascii_rx_pkg.sv
// Shared constants, receive FSM encoding and character translation for the
// Apple-I keyboard receive path.
package ascii_rx_pkg;

    localparam logic [6:0] ASC_CR       = 7'h0D;
    localparam logic [6:0] ASC_LF       = 7'h0A;
    localparam logic [6:0] ASC_ESC      = 7'h1B;
    localparam logic [6:0] ASC_LC_A     = 7'h61;
    localparam logic [6:0] ASC_LC_Z     = 7'h7A;
    localparam logic [6:0] ASC_CASE_OFS = 7'h20;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

    // Strip bit 7, map LF to CR and optionally fold lower case to upper case.
    function automatic logic [6:0] ascii_xlate(input logic [7:0] ch, input logic upcase);
        logic [6:0] c;
        c = ch[6:0];
        if (c == ASC_LF) begin
            c = ASC_CR;
        end else if (upcase && (c >= ASC_LC_A) && (c <= ASC_LC_Z)) begin
            c = c - ASC_CASE_OFS;
        end
        return c;
    endfunction

endpackage

// File: rtl/ascii_char_fifo.sv
// Synchronous FIFO for keyboard characters. A push into a full FIFO is
// accepted when a pop happens on the same edge.
module ascii_char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap modulo DEPTH; the count separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ascii_rx_mux.sv
// Merges PS/2 keystrokes and the paced paste stream into the PIA-style
// receive register read by the 6502 at $D010/$D011.
module ascii_rx_mux
    import ascii_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PACE       = 4000,
    parameter bit          UPCASE     = 1'b1
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [7:0] ps2_ascii,
    input  logic       ps2_strobe,
    input  logic [7:0] file_ascii,
    input  logic       file_valid,
    output logic       file_ack,
    output logic       file_abort,
    input  logic       cs,
    input  logic       address,
    output logic [7:0] dout,
    output logic       rx_ready,
    output logic       overflow
);

    localparam int unsigned PACE_W = $clog2(PACE) + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(PACE - 1);

    rx_state_e         state_q;
    rx_state_e         state_d;
    logic [6:0]        rx_data_q;
    logic [PACE_W-1:0] pace_q;
    logic [7:0]        dout_q;
    logic              file_ack_q;
    logic              file_abort_q;
    logic              overflow_q;

    logic [6:0]        kb_char_c;
    logic [6:0]        paste_char_c;
    logic              kb_valid_c;
    logic              push_c;
    logic              drop_c;
    logic              pop_c;
    logic              paste_take_c;
    logic              paste_load_c;
    logic              load_c;
    logic              rd_data_c;
    logic              rx_full_c;

    logic [6:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  unused_fifo_count;

    assign kb_char_c    = ascii_xlate(ps2_ascii, UPCASE);
    assign paste_char_c = ascii_xlate(file_ascii, UPCASE);
    assign kb_valid_c   = ps2_strobe && (kb_char_c != '0);
    assign push_c       = kb_valid_c && (!fifo_full || pop_c);
    assign drop_c       = kb_valid_c && fifo_full && !pop_c;
    assign paste_load_c = paste_take_c && (paste_char_c != '0);
    assign load_c       = pop_c || paste_load_c;
    assign rd_data_c    = cs && !address;
    assign rx_full_c    = (state_q == RX_FULL);

    ascii_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (7)
    ) u_fifo (
        .clk     (clk25),
        .rst     (rst),
        .push_i  (push_c),
        .din_i   (kb_char_c),
        .pop_i   (pop_c),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // Receive FSM state register.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q <= RX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on any load, empty on a data read (never both on one edge).
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_EMPTY: if (load_c)    state_d = RX_FULL;
            RX_FULL:  if (rd_data_c) state_d = RX_EMPTY;
            default:                 state_d = RX_EMPTY;
        endcase
    end

    // Load source select: FIFO first; paste yields to a keystroke arriving this
    // cycle and to an ack still in flight, so the producer can advance first.
    always_comb begin
        pop_c        = 1'b0;
        paste_take_c = 1'b0;
        if (state_q == RX_EMPTY) begin
            if (!fifo_empty) begin
                pop_c = 1'b1;
            end else if (file_valid && (pace_q == '0) && !kb_valid_c && !file_ack_q) begin
                paste_take_c = 1'b1;
            end
        end
    end

    // Receive data, pacing, handshake pulses, sticky overflow and CPU read data.
    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_data_q    <= '0;
            pace_q       <= '0;
            dout_q       <= '0;
            file_ack_q   <= 1'b0;
            file_abort_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (load_c) begin
                rx_data_q <= pop_c ? fifo_head : paste_char_c;
            end
            if (paste_take_c) begin
                pace_q <= PACE_RELOAD;
            end else if (pace_q != '0) begin
                pace_q <= pace_q - PACE_W'(1);
            end
            file_ack_q   <= paste_take_c;
            file_abort_q <= kb_valid_c && (kb_char_c == ASC_ESC);
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
            if (cs) begin
                dout_q <= address ? {rx_full_c, 7'b0} : {1'b1, rx_data_q};
            end
        end
    end

    assign file_ack   = file_ack_q;
    assign file_abort = file_abort_q;
    assign dout       = dout_q;
    assign rx_ready   = rx_full_c;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ascii_rx_mux.sv
// Self-checking bench for ascii_rx_mux: translation table, hand-written
// handshake/priority/overflow/reset sequences and randomized keyboard bursts.
module tb_ascii_rx_mux;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PACE  = 16;

    logic       clk25      = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] ps2_ascii  = 8'h00;
    logic       ps2_strobe = 1'b0;
    logic [7:0] file_ascii = 8'h00;
    logic       file_valid = 1'b0;
    logic       file_ack;
    logic       file_abort;
    logic       cs         = 1'b0;
    logic       address    = 1'b0;
    logic [7:0] dout;
    logic       rx_ready;
    logic       overflow;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int ack_cnt   = 0;
    int abort_cnt = 0;
    logic [7:0] paste_q [$];
    int         ack_cyc [$];

    typedef struct {
        logic [7:0] ch;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    ascii_rx_mux #(
        .FIFO_DEPTH (DEPTH),
        .PACE       (PACE),
        .UPCASE     (1'b1)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .ps2_ascii  (ps2_ascii),
        .ps2_strobe (ps2_strobe),
        .file_ascii (file_ascii),
        .file_valid (file_valid),
        .file_ack   (file_ack),
        .file_abort (file_abort),
        .cs         (cs),
        .address    (address),
        .dout       (dout),
        .rx_ready   (rx_ready),
        .overflow   (overflow)
    );

    always #20 clk25 = ~clk25;

    // Paste producer: holds the head character until it is acknowledged.
    always @(posedge clk25) begin
        logic [7:0] gone;
        #2;
        cyc++;
        if (file_ack) begin
            ack_cnt++;
            ack_cyc.push_back(cyc);
            if (paste_q.size() > 0) gone = paste_q.pop_front();
        end
        if (file_abort) abort_cnt++;
        file_valid = (paste_q.size() != 0);
        file_ascii = file_valid ? paste_q[0] : 8'h00;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        paste_q.delete();
        ack_cyc.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] c);
        ps2_ascii  = c;
        ps2_strobe = 1'b1;
        tick();
        ps2_strobe = 1'b0;
        ps2_ascii  = 8'h00;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        cs      = 1'b1;
        address = a;
        tick();
        cs      = 1'b0;
        d       = dout;
    endtask

    task automatic expect_char(input string name, input int budget, input logic [7:0] exp);
        logic [7:0] d;
        for (int i = 0; i < budget && !rx_ready; i++) tick();
        check({name, "_ready"}, 8'(rx_ready), 8'h01);
        cpu_read(1'b0, d);
        check(name, d, exp);
    endtask

    // Expected $D010 byte for a raw character, or 0 when it is discarded.
    function automatic logic [7:0] model_read(input logic [7:0] raw);
        int v;
        v = int'(raw) % 128;
        if (v == 10) v = 13;
        if (v >= 97 && v <= 122) v = v - 32;
        return (v == 0) ? 8'h00 : 8'(128 + v);
    endfunction

    initial begin
        vec_t       vecs [12];
        logic [7:0] d;
        logic [7:0] exp_q [$];
        logic       ovf;
        int         base;
        int         gap;
        int         k;
        logic [7:0] c;
        logic [7:0] m;

        vecs[0]  = '{8'h61, 1'b1, 8'hC1};
        vecs[1]  = '{8'h7A, 1'b1, 8'hDA};
        vecs[2]  = '{8'h41, 1'b1, 8'hC1};
        vecs[3]  = '{8'h0A, 1'b1, 8'h8D};
        vecs[4]  = '{8'h8A, 1'b1, 8'h8D};
        vecs[5]  = '{8'hE1, 1'b1, 8'hC1};
        vecs[6]  = '{8'h00, 1'b0, 8'h00};
        vecs[7]  = '{8'h80, 1'b0, 8'h00};
        vecs[8]  = '{8'h7B, 1'b1, 8'hFB};
        vecs[9]  = '{8'h60, 1'b1, 8'hE0};
        vecs[10] = '{8'h0D, 1'b1, 8'h8D};
        vecs[11] = '{8'hFF, 1'b1, 8'hFF};

        // Reset state
        idle(2);
        rst = 1'b0;
        check("rst_dout", dout, 8'h00);
        check("rst_ready", 8'(rx_ready), 8'h00);
        check("rst_overflow", 8'(overflow), 8'h00);
        check("rst_ack", 8'(file_ack), 8'h00);
        check("rst_abort", 8'(file_abort), 8'h00);
        cpu_read(1'b1, d);
        check("rst_status", d, 8'h00);

        // Single keystroke with one-cycle FIFO latency
        strobe(8'h61);
        check("kb_latency", 8'(rx_ready), 8'h00);
        expect_char("kb_a", 1, 8'hC1);
        cpu_read(1'b1, d);
        check("kb_status_after", d, 8'h00);

        // Translation table
        foreach (vecs[i]) begin
            strobe(vecs[i].ch);
            idle(1);
            check("xlate_ready", 8'(rx_ready), 8'(vecs[i].rdy));
            if (vecs[i].rdy) begin
                cpu_read(1'b0, d);
                check("xlate_data", d, vecs[i].exp);
                check("xlate_clear", 8'(rx_ready), 8'h00);
            end
        end

        // Paced paste stream
        do_reset();
        paste_q.push_back(8'h0A);
        paste_q.push_back(8'h68);
        expect_char("paste_lf", 8, 8'h8D);
        expect_char("paste_h", 40, 8'hC8);
        idle(1);
        check("paste_acks", 8'(ack_cyc.size()), 8'h02);
        gap = (ack_cyc.size() >= 2) ? (ack_cyc[1] - ack_cyc[0]) : 0;
        check("paste_gap", 8'(gap >= int'(PACE)), 8'h01);

        // Keyboard wins over an eligible paste character
        do_reset();
        idle(1);
        base = ack_cnt;
        paste_q.push_back(8'h70);
        strobe(8'h42);
        check("prio_no_ack0", 8'(file_ack), 8'h00);
        idle(4);
        check("prio_ready", 8'(rx_ready), 8'h01);
        check("prio_no_ack", 8'(ack_cnt - base), 8'h00);
        cpu_read(1'b0, d);
        check("prio_kb", d, 8'hC2);
        expect_char("prio_paste", 40, 8'hD0);
        check("prio_ack", 8'(ack_cnt - base), 8'h01);

        // Nine keystrokes fit, the tenth overflows
        do_reset();
        for (int i = 0; i < 9; i++) strobe(8'(8'h41 + i));
        check("ovf_nine", 8'(overflow), 8'h00);
        strobe(8'h4A);
        check("ovf_ten", 8'(overflow), 8'h01);
        for (int i = 0; i < 9; i++) expect_char("ovf_drain", 4, 8'(8'hC1 + i));
        idle(3);
        check("ovf_empty", 8'(rx_ready), 8'h00);
        check("ovf_sticky", 8'(overflow), 8'h01);

        // ESC during paste
        do_reset();
        idle(1);
        base = abort_cnt;
        paste_q.push_back(8'h78);
        strobe(8'h1B);
        check("esc_pulse", 8'(file_abort), 8'h01);
        tick();
        check("esc_pulse_end", 8'(file_abort), 8'h00);
        expect_char("esc_data", 4, 8'h9B);
        expect_char("esc_paste", 40, 8'hD8);
        idle(2);
        check("esc_abort_count", 8'(abort_cnt - base), 8'h01);

        // Reset mid-stream
        do_reset();
        paste_q.push_back(8'h71);
        for (int i = 0; i < 10; i++) strobe(8'(8'h61 + i));
        cpu_read(1'b0, d);
        check("mid_pre_read", d, 8'hC1);
        strobe(8'h1B);
        rst = 1'b1;
        tick();
        check("mid_dout", dout, 8'h00);
        check("mid_ready", 8'(rx_ready), 8'h00);
        check("mid_ack", 8'(file_ack), 8'h00);
        check("mid_abort", 8'(file_abort), 8'h00);
        check("mid_overflow", 8'(overflow), 8'h00);
        rst = 1'b0;
        expect_char("mid_paste", 10, 8'hD1);
        idle(3);
        check("mid_no_more", 8'(rx_ready), 8'h00);

        // Randomized keyboard bursts against a capacity model
        for (int r = 0; r < 20; r++) begin
            do_reset();
            exp_q.delete();
            ovf = 1'b0;
            k = int'($urandom_range(0, 11));
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
                else c = 8'($urandom_range(0, 255));
                m = model_read(c);
                if (m != 8'h00) begin
                    if (exp_q.size() < int'(DEPTH) + 1) exp_q.push_back(m);
                    else ovf = 1'b1;
                end
                strobe(c);
                idle(int'($urandom_range(0, 2)));
            end
            idle(2);
            check("rnd_overflow", 8'(overflow), 8'(ovf));
            foreach (exp_q[j]) expect_char("rnd_data", 4, exp_q[j]);
            idle(3);
            check("rnd_empty", 8'(rx_ready), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
